serial_comparator: RTL and testbench



---
 rtl/cmp_pkg.sv | 12 +
 rtl/bit_cmp_cell.sv | 15 +
 rtl/serial_comparator.sv | 136 +++++++++++++
 tb/tb_serial_comparator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared constants for the bit-serial magnitude comparator.
// State encoding and default operand width.
package cmp_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/bit_cmp_cell.sv
// Single-bit magnitude compare cell.
// gt means bi > ai, lt means bi < ai.
module bit_cmp_cell (
  input  logic ai,
  input  logic bi,
  output logic gt,
  output logic lt,
  output logic eq
);

  assign gt = bi & ~ai;
  assign lt = ~bi & ai;
  assign eq = ai ~^ bi;

endmodule

// File: rtl/serial_comparator.sv
// MSB-first bit-serial magnitude comparator with start/done handshake.
// Stops at the first differing bit; results held until the next start.
module serial_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic          busy,
  output logic          done,
  output logic          x,
  output logic          y,
  output logic          z,
  output logic [CW:0]   cycles
);

  localparam logic [CW-1:0] IDX_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] IDX_ONE = CW'(1);
  localparam logic [CW:0]   CYC_ONE = (CW + 1)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW:0]      cycles_q, cycles_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             x_q, x_d;
  logic             y_q, y_d;
  logic             z_q, z_d;

  logic gt, lt, eq;

  bit_cmp_cell u_msb (
    .ai (sa_q[WIDTH-1]),
    .bi (sb_q[WIDTH-1]),
    .gt (gt),
    .lt (lt),
    .eq (eq)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    idx_d    = idx_q;
    cycles_d = cycles_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d     = a;
          sb_d     = b;
          idx_d    = IDX_MAX;
          cycles_d = '0;
          x_d      = 1'b0;
          y_d      = 1'b0;
          z_d      = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_SCAN;
        end
      end
      ST_SCAN: begin
        cycles_d = cycles_q + CYC_ONE;
        unique case (1'b1)
          gt: begin
            x_d     = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
          lt: begin
            y_d     = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
          (eq && idx_q == '0): begin
            z_d     = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
          default: begin
            sa_d  = {sa_q[WIDTH-2:0], 1'b0};
            sb_d  = {sb_q[WIDTH-2:0], 1'b0};
            idx_d = idx_q - IDX_ONE;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      idx_q    <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      idx_q    <= idx_d;
      cycles_q <= cycles_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign x      = x_q;
  assign y      = y_q;
  assign z      = z_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized and directed bench for serial_comparator.
// Reference results come from plain unsigned arithmetic on a and b.
module tb_serial_comparator;

  localparam int W  = 4;
  localparam int CW = $clog2(W);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic          x;
  logic          y;
  logic          z;
  logic [CW:0]   cycles;

  int n_checks;
  int n_errors;

  serial_comparator #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .x      (x),
    .y      (y),
    .z      (z),
    .cycles (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_diff(input logic [W-1:0] va,
                                    input logic [W-1:0] vb);
    logic [W-1:0] d;
    d = va ^ vb;
    for (int i = W - 1; i >= 0; i--)
      if (d[i]) return W - i;
    return W;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full compare; optionally pokes start/a/b while the scan runs.
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input bit disturb);
    int k;
    int n;
    bit seen;
    k = first_diff(ta, tb_);
    start = 1'b1;
    a = ta;
    b = tb_;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("flags_clear", 32'({x, y, z}), 32'd0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < W + 3) begin
      if (disturb) begin
        start = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      n++;
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
      end else begin
        check("busy_during_scan", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(n), 32'(k));
      check("x", 32'(x), 32'(tb_ > ta));
      check("y", 32'(y), 32'(tb_ < ta));
      check("z", 32'(z), 32'(tb_ == ta));
      check("cycles", 32'(cycles), 32'(k));
      check("busy_at_done", 32'(busy), 32'd0);
      tick();
      check("done_width", 32'(done), 32'd0);
      check("x_held", 32'(x), 32'(tb_ > ta));
      check("z_held", 32'(z), 32'(tb_ == ta));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    check("rst_outputs", 32'({busy, done, x, y, z, cycles}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_cmp(4'b0000, 4'b0001, 1'b0);
    run_cmp(4'b0010, 4'b0000, 1'b0);
    run_cmp(4'b1010, 4'b1100, 1'b0);
    run_cmp(4'b1101, 4'b1101, 1'b0);

    // Second request during scan must be ignored.
    start = 1'b1;
    a = 4'b0000;
    b = 4'b1000;
    tick();
    a = 4'b1111;
    b = 4'b0000;
    tick();
    start = 1'b0;
    check("ignore_done", 32'(done), 32'd1);
    check("ignore_x", 32'(x), 32'd1);
    check("ignore_cycles", 32'(cycles), 32'd1);
    tick();
    check("ignore_idle", 32'({busy, done}), 32'd0);

    // Asynchronous reset in the middle of a scan.
    start = 1'b1;
    a = 4'b0101;
    b = 4'b0100;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({busy, done, x, y, z, cycles}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'({busy, done}), 32'd0);
    run_cmp(4'b0011, 4'b0011, 1'b0);

    // Back-to-back with start held high.
    start = 1'b1;
    a = 4'b1000;
    b = 4'b0000;
    tick();
    a = 4'b0000;
    b = 4'b1000;
    tick();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_y", 32'(y), 32'd1);
    tick();
    check("b2b_rearm", 32'({busy, done, x, y, z}), 32'b10000);
    start = 1'b0;
    tick();
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_x", 32'(x), 32'd1);
    check("b2b_cycles", 32'(cycles), 32'd1);
    tick();

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_cmp(ra, rb, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
